// File: rtl/execute_pipe_if.sv
// Beat-level bus of the SIMD execute stage: operand side (in_*) and result side (out_*).
interface execute_pipe_if #(
   parameter int N     = 32,
   parameter int LANES = 8
);
   logic                       in_valid;
   logic                       in_ready;
   logic [LANES-1:0]           lane_en;
   logic [2:0]                 instr;
   logic [LANES-1:0][N-1:0]    dataA;
   logic [LANES-1:0][N-1:0]    dataB;
   logic                       out_valid;
   logic                       out_ready;
   logic [LANES-1:0]           out_lane_en;
   logic [LANES-1:0][N-1:0]    data_out;
   logic [LANES-1:0]           overflow;

   modport master (
      output in_valid, lane_en, instr, dataA, dataB, out_ready,
      input  in_ready, out_valid, out_lane_en, data_out, overflow
   );

   modport slave (
      input  in_valid, lane_en, instr, dataA, dataB, out_ready,
      output in_ready, out_valid, out_lane_en, data_out, overflow
   );
endinterface

// File: rtl/execute_pipe.sv
// Pipelined multi-lane signed Q-format SIMD execute stage with valid/ready flow control.
// Define EXEC_SAT_EN to saturate overflowing lanes instead of wrapping them.
module execute_pipe #(
   parameter int N      = 32,
   parameter int Q      = 16,
   parameter int LANES  = 8,
   parameter int STAGES = 2
) (
   input logic           clk,
   input logic           rstn,
   execute_pipe_if.slave bus
);
   localparam int W2 = 2 * N;
`ifdef EXEC_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef logic signed [W2-1:0] wide_t;

   // Full-precision result in 2N bits; every opcode's exact value fits there.
   function automatic wide_t alu_wide(input logic [2:0] op,
                                      input logic signed [N-1:0] a,
                                      input logic signed [N-1:0] b);
      wide_t aw, bw, r;
      aw = {{N{a[N-1]}}, a};
      bw = {{N{b[N-1]}}, b};
      case (op)
         3'b000:  r = aw + bw;
         3'b001:  r = aw - bw;
         3'b010:  r = (aw * bw) >>> Q;
         3'b011:  r = (aw < bw) ? aw : bw;
         3'b100:  r = (aw > bw) ? aw : bw;
         3'b101:  r = a[N-1] ? -aw : aw;
         3'b110:  r = aw;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Upper N+1 bits all equal means the value is representable in N bits.
   function automatic logic fits(input logic [N:0] top);
      return (top == '0) || (&top);
   endfunction

   function automatic logic [N-1:0] narrow(input logic [N-1:0] lo,
                                           input logic neg,
                                           input logic ovf);
      if (ovf && SAT_EN)
         return neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      return lo;
   endfunction

   logic                    vld_p [STAGES];
   logic [LANES-1:0][N-1:0] res_p [STAGES];
   logic [LANES-1:0]        ovf_p [STAGES];
   logic [LANES-1:0]        len_p [STAGES];

   logic                    stall;
   logic [LANES-1:0]        en_c;
   logic [LANES-1:0][N-1:0] res_c;
   logic [LANES-1:0]        ovf_c;
   wide_t                   wr;
   logic                    lane_ovf;

   assign stall        = vld_p[STAGES-1] && !bus.out_ready;
   assign bus.in_ready = !stall;
   // Bubbles carry zeroed lanes so nothing stale shows up behind them.
   assign en_c         = bus.lane_en & {LANES{bus.in_valid}};

   always_comb begin
      res_c    = '0;
      ovf_c    = '0;
      wr       = '0;
      lane_ovf = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         wr       = alu_wide(bus.instr, bus.dataA[i], bus.dataB[i]);
         lane_ovf = !fits(wr[W2-1:N-1]);
         if (en_c[i]) begin
            res_c[i] = narrow(wr[N-1:0], wr[W2-1], lane_ovf);
            ovf_c[i] = lane_ovf;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < STAGES; s++) begin
            vld_p[s] <= 1'b0;
            res_p[s] <= '0;
            ovf_p[s] <= '0;
            len_p[s] <= '0;
         end
      end else if (!stall) begin
         // stage 0: computed result captured
         vld_p[0] <= bus.in_valid;
         res_p[0] <= res_c;
         ovf_p[0] <= ovf_c;
         len_p[0] <= en_c;
         // stages 1..STAGES-1: pure delay registers
         for (int s = 1; s < STAGES; s++) begin
            vld_p[s] <= vld_p[s-1];
            res_p[s] <= res_p[s-1];
            ovf_p[s] <= ovf_p[s-1];
            len_p[s] <= len_p[s-1];
         end
      end
   end

   assign bus.out_valid   = vld_p[STAGES-1];
   assign bus.data_out    = res_p[STAGES-1];
   assign bus.overflow    = ovf_p[STAGES-1];
   assign bus.out_lane_en = len_p[STAGES-1];
endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe: STAGES=2 main instance plus STAGES=1 and STAGES=4 instances.
module tb_execute_pipe;
   localparam int N = 32;
   localparam int LANES = 8;
   localparam int Q = 16;

   typedef logic [LANES-1:0][N-1:0] vec_t;
   typedef struct {
      vec_t             d;
      logic [LANES-1:0] o;
      logic [LANES-1:0] en;
      int               acc;
      bit               lat;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   execute_pipe_if #(.N(N), .LANES(LANES)) ifc  ();
   execute_pipe_if #(.N(N), .LANES(LANES)) ifc1 ();
   execute_pipe_if #(.N(N), .LANES(LANES)) ifc4 ();

   execute_pipe #(.N(N), .Q(Q), .LANES(LANES), .STAGES(2)) dut  (.clk(clk), .rstn(rstn), .bus(ifc.slave));
   execute_pipe #(.N(N), .Q(Q), .LANES(LANES), .STAGES(1)) dut1 (.clk(clk), .rstn(rstn), .bus(ifc1.slave));
   execute_pipe #(.N(N), .Q(Q), .LANES(LANES), .STAGES(4)) dut4 (.clk(clk), .rstn(rstn), .bus(ifc4.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: exact 64-bit arithmetic, then range test against the 32-bit limits.
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic o);
      longint la, lb, w, maxv, minv;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      maxv = 2147483647;
      minv = -maxv - 1;
      case (op)
         3'd0: w = la + lb;
         3'd1: w = la - lb;
         3'd2: w = (la * lb) >>> Q;
         3'd3: w = (la < lb) ? la : lb;
         3'd4: w = (la > lb) ? la : lb;
         3'd5: w = (la < 0) ? -la : la;
         3'd6: w = la;
         default: w = 0;
      endcase
      o = (w > maxv) || (w < minv);
      r = w[31:0];
`ifdef EXEC_SAT_EN
      if (o) r = (w < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
   endfunction

   // Called at posedge+#1; returns at posedge+#1 of the accepting edge with in_valid dropped.
   task automatic send(input logic [7:0] en, input logic [2:0] op, input vec_t a, input vec_t b, input bit lat);
      exp_t e;
      logic [31:0] r;
      logic o;
      bit rdy, done;
      ifc.in_valid = 1'b1;
      ifc.lane_en  = en;
      ifc.instr    = op;
      ifc.dataA    = a;
      ifc.dataB    = b;
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk) rdy = ifc.in_ready;
         @(posedge clk);
         if (rdy) begin
            for (int i = 0; i < LANES; i++) begin
               model(op, a[i], b[i], r, o);
               e.d[i] = en[i] ? r : 32'h0;
               e.o[i] = en[i] ? o : 1'b0;
            end
            e.en  = en;
            e.acc = cyc;
            e.lat = lat;
            sb.push_back(e);
            done = 1'b1;
         end
      end
      if (!done) chk("accept_timeout", 1'b0, 1'b1);
      #1 ifc.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && sb.size() != 0; t++) idle(1);
      chk("drain", sb.size(), 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h8000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h0;
         3: return 32'hFFFF_FFFF;
         4: return $urandom_range(0, 32'h0003_FFFF) - 32'h0002_0000;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: pops and checks on each handshake, verifies in_ready and stall stability.
   bit          mon_seen = 1'b0;
   bit          held_v = 1'b0;
   logic [255:0] held_d;
   logic [15:0]  held_f;
   always @(negedge clk) begin
      if (!rstn) begin
         mon_seen = 1'b0;
         held_v   = 1'b0;
      end else begin
         chk("in_ready", ifc.in_ready, !(ifc.out_valid && !ifc.out_ready));
         if (held_v) begin
            chk("stall_data", ifc.data_out, held_d);
            chk("stall_flags", {ifc.out_lane_en, ifc.overflow}, held_f);
         end
         if (ifc.out_valid) begin
            if (sb.size() == 0) chk("spurious_out", ifc.out_valid, 1'b0);
            else begin
               if (!mon_seen && sb[0].lat) chk("latency", cyc - sb[0].acc, 2);
               mon_seen = 1'b1;
               if (ifc.out_ready) begin
                  chk("data", ifc.data_out, sb[0].d);
                  chk("ovf", ifc.overflow, sb[0].o);
                  chk("lane_en", ifc.out_lane_en, sb[0].en);
                  void'(sb.pop_front());
                  mon_seen = 1'b0;
               end
            end
         end
         held_v = ifc.out_valid && !ifc.out_ready;
         held_d = ifc.data_out;
         held_f = {ifc.out_lane_en, ifc.overflow};
      end
   end

   // Single beat into the STAGES=1 and STAGES=4 instances; expected result is lane 0 only.
   task automatic run_alt(input logic [7:0] en, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp0);
      int lat1, lat4;
      vec_t ev;
      ev = '0;
      ev[0] = exp0;
      ifc1.in_valid = 1'b1; ifc1.lane_en = en; ifc1.instr = op; ifc1.dataA = '0; ifc1.dataB = '0;
      ifc4.in_valid = 1'b1; ifc4.lane_en = en; ifc4.instr = op; ifc4.dataA = '0; ifc4.dataB = '0;
      ifc1.dataA[0] = a; ifc1.dataB[0] = b;
      ifc4.dataA[0] = a; ifc4.dataB[0] = b;
      @(negedge clk);
      chk("alt_in_ready", {ifc1.in_ready, ifc4.in_ready}, 2'b11);
      @(posedge clk);
      #1 ifc1.in_valid = 1'b0; ifc4.in_valid = 1'b0;
      lat1 = 0; lat4 = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (ifc1.out_valid && lat1 == 0) begin
            lat1 = n;
            chk("s1_data", ifc1.data_out, ev);
            chk("s1_lane_en", ifc1.out_lane_en, en & 8'h01);
         end
         if (ifc4.out_valid && lat4 == 0) begin
            lat4 = n;
            chk("s4_data", ifc4.data_out, ev);
            chk("s4_lane_en", ifc4.out_lane_en, en & 8'h01);
         end
      end
      chk("s1_latency", lat1, 1);
      chk("s4_latency", lat4, 4);
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin : main
      vec_t va, vb;
      logic [2:0] op;
      ifc.in_valid = 0; ifc.lane_en = 0; ifc.instr = 0; ifc.dataA = '0; ifc.dataB = '0; ifc.out_ready = 1;
      ifc1.in_valid = 0; ifc1.lane_en = 0; ifc1.instr = 0; ifc1.dataA = '0; ifc1.dataB = '0; ifc1.out_ready = 1;
      ifc4.in_valid = 0; ifc4.lane_en = 0; ifc4.instr = 0; ifc4.dataA = '0; ifc4.dataB = '0; ifc4.out_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", ifc.out_valid, 1'b0);
      chk("rst_data", ifc.data_out, '0);
      chk("rst_flags", {ifc.out_lane_en, ifc.overflow}, 16'h0);
      chk("rst_in_ready", ifc.in_ready, 1'b1);
      @(posedge clk);
      #1 rstn = 1'b1;

      // Directed: Q16 multiply on lane 0 only, then saturating-edge cases on all lanes.
      va = '0; vb = '0; va[0] = 32'h0001_8000; vb[0] = 32'h0002_0000;
      send(8'h01, 3'b010, va, vb, 1'b1);
      idle(4);
      send(8'hFF, 3'b000, {8{32'h7FFF_0000}}, {8{32'h0002_0000}}, 1'b1);
      send(8'hFF, 3'b101, {8{32'h8000_0000}}, {8{32'h0}}, 1'b1);
      send(8'hFF, 3'b011, {8{32'hFFFF_FFFF}}, {8{32'h0000_0001}}, 1'b1);
      send(8'hFF, 3'b001, {8{32'h8000_0000}}, {8{32'h0000_0001}}, 1'b1);
      send(8'hA5, 3'b100, {8{32'hFFFF_0000}}, {8{32'h0000_1000}}, 1'b1);
      send(8'hFF, 3'b010, {8{32'h7FFF_FFFF}}, {8{32'h7FFF_FFFF}}, 1'b1);
      send(8'hFF, 3'b010, {8{32'hFFFF_FFFF}}, {8{32'h0000_0001}}, 1'b1);
      send(8'h3C, 3'b110, {8{32'h1234_5678}}, {8{32'h0}}, 1'b1);
      send(8'hFF, 3'b111, {8{32'hDEAD_BEEF}}, {8{32'h7FFF_FFFF}}, 1'b1);
      send(8'h00, 3'b000, {8{32'h7FFF_FFFF}}, {8{32'h7FFF_FFFF}}, 1'b1);
      drain();

      // Random beats with occasional bubbles.
      for (int k = 0; k < 40; k++) begin
         op = 3'($urandom_range(0, 7));
         for (int i = 0; i < LANES; i++) begin
            va[i] = pick();
            vb[i] = pick();
         end
         send(8'($urandom), op, va, vb, 1'b1);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      drain();

      // Backpressure: six tagged beats back to back, downstream stalls for cycles 3..7.
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               for (int i = 0; i < LANES; i++) va[i] = 32'((k + 1) * 16 + i);
               send(8'hFF, 3'b110, va, '0, 1'b0);
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 ifc.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 ifc.out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two beats in flight: both must vanish.
      send(8'hFF, 3'b110, {8{32'h0000_00AA}}, '0, 1'b1);
      send(8'hFF, 3'b110, {8{32'h0000_00BB}}, '0, 1'b1);
      rstn = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_out_valid", ifc.out_valid, 1'b0);
      chk("mid_rst_data", ifc.data_out, '0);
      chk("mid_rst_flags", {ifc.out_lane_en, ifc.overflow}, 16'h0);
      @(posedge clk);
      #1 rstn = 1'b1;
      idle(8);
      send(8'h01, 3'b000, {8{32'h0000_0005}}, {8{32'h0000_0007}}, 1'b1);
      drain();

      // Latency of the shallow and deep builds, including an all-lanes-off beat.
      run_alt(8'h01, 3'b010, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000);
      run_alt(8'h00, 3'b000, 32'h1111_1111, 32'h2222_2222, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
